// File: rtl/audio_pacer.sv
// Paced sample FIFO: bursty one-cycle input strobes in, one strobe per sample period out; tick-to-out_valid latency 1 clock.
// No input backpressure: a push into a full FIFO is dropped and counted, a starved tick repeats the last sample and is counted.
module audio_pacer #(
  parameter int clock_max   = 25_000_000,
  parameter int sample_rate = 8_000,
  parameter int depth_log2  = 4,
  parameter int prefill     = 8
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [15:0]           in_sample,
  output logic                  out_valid,
  output logic [15:0]           out_sample,
  output logic [depth_log2:0]   level,
  output logic                  playing,
  output logic [7:0]            overflow_cnt,
  output logic [7:0]            underrun_cnt
);
  localparam int DIV   = clock_max / sample_rate;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << depth_log2;

  localparam logic [CW-1:0]         CNT_LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0]         CNT_ONE     = CW'(1);
  localparam logic [depth_log2:0]   LVL_FULL    = (depth_log2 + 1)'(DEPTH);
  localparam logic [depth_log2:0]   LVL_PREFILL = (depth_log2 + 1)'(prefill);
  localparam logic [depth_log2:0]   LVL_ONE     = (depth_log2 + 1)'(1);
  localparam logic [depth_log2-1:0] PTR_ONE     = depth_log2'(1);

  typedef enum logic {FILL, RUN} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic [15:0]           mem [DEPTH];

  logic tick;
  logic pop;
  logic underrun;
  logic push;
  logic drop;

  // flush masks every side effect of the cycle it lands on, including the input strobe
  assign tick     = (cnt == CNT_LAST);
  assign pop      = tick && (state == RUN) && (level != '0) && !flush;
  assign underrun = tick && (state == RUN) && (level == '0) && !flush;
  assign push     = in_valid && !flush && ((level != LVL_FULL) || pop);
  assign drop     = in_valid && !flush && (level == LVL_FULL) && !pop;

  always_ff @(posedge clk_25mhz) begin
    if (push) begin
      mem[wr_ptr] <= in_sample;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      out_valid    <= 1'b0;
      out_sample   <= 16'h0000;
      playing      <= 1'b0;
      overflow_cnt <= 8'd0;
      underrun_cnt <= 8'd0;
    end else if (flush) begin
      state     <= FILL;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      playing   <= 1'b0;
    end else begin
      cnt       <= tick ? '0 : cnt + CNT_ONE;
      out_valid <= pop || underrun;

      // the read uses the pre-edge head, so a same-cycle push never overtakes it
      if (pop) begin
        out_sample <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_ONE;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      if (drop && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
      if (underrun && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end

      case (state)
        FILL: begin
          if (level >= LVL_PREFILL) begin
            state   <= RUN;
            playing <= 1'b1;
          end
        end
        RUN: begin
          if (underrun) begin
            state   <= FILL;
            playing <= 1'b0;
          end
        end
        default: begin
          state   <= FILL;
          playing <= 1'b0;
        end
      endcase
    end
  end
endmodule
